sw_debounce: RTL and testbench

- Input-conditioning stage for slide switches and push buttons on the board.
- Synchronises N asynchronous raw inputs to `clk` and rejects contact bounce.
- Produces clean levels plus single-cycle rise and fall pulses.
- The clean levels feed the two-input logic-gate blocks directly, e.g. `db_out[0]` to operand a and `db_out[1]` to operand b.

---
 rtl/debounce_pkg.sv | 17 +
 rtl/debounce_chan.sv | 119 +++++++++++
 rtl/sw_debounce.sv | 31 +++
 tb/tb_sw_debounce.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch/button debounce blocks: the per-channel
// state encoding and the default stability window.
package debounce_pkg;

  // Bit 1 of the encoding is the debounced level itself (LO/WAIT_HI = 0,
  // HI/WAIT_LO = 1), so the clean output comes straight off the state flop.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } deb_state_e;

  // Samples the synchronised input must hold the new level before db_out moves.
  localparam int DEFAULT_STABLE_CYCLES = 16;

endpackage : debounce_pkg

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, saturating stability counter,
// four-state level FSM and registered one-cycle rise/fall pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  deb_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;

  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Bring the asynchronous raw level into the clk domain; only r_sync2 is used.
  // NOTE: the async reset clears every flop here, so a reset mid-debounce
  // throws the partial count away rather than resuming it after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // giving a true two-stage chain; blocking would collapse it to one.
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state logic: a level must persist for the full window; any bounce
  // while waiting drops back to the stable state with no partial credit.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves one unassigned and infers a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!r_sync2) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (r_sync2) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_db   = r_state[1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule : debounce_chan

// File: rtl/sw_debounce.sv
// Input conditioning for N slide switches / push buttons: one independent
// debounce channel per raw input, all outputs registered.
module sw_debounce
  import debounce_pkg::*;
#(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] db_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  // One self-contained channel per input bit.
  for (genvar g = 0; g < N; g++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .i_raw (raw_in[g]),
      .o_db  (db_out[g]),
      .o_rise(rise[g]),
      .o_fall(fall[g])
    );
  end

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (N=2, STABLE_CYCLES=4). A run-length reference model
// says db flips once the FSM has seen STABLE_CYCLES+1 consecutive
// synchronised samples that differ from the current level.
module tb_sw_debounce;

  localparam int N  = 2;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] db_out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_rise = '0, m_fall = '0;
  int           m_run [N];

  sw_debounce #(.N(N), .STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_in(raw_in),
    .db_out(db_out),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  // One clock edge: the level decision sees the pre-edge s2, then the delay line shifts.
  task automatic model_edge(input logic [N-1:0] raw);
    for (int i = 0; i < N; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == SC + 1) begin
          m_db[i] = m_s2[i];
          if (m_s2[i]) m_rise[i] = 1'b1;
          else         m_fall[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_db"},   32'(db_out), 32'(m_db));
    check({tag, "_rise"}, 32'(rise),   32'(m_rise));
    check({tag, "_fall"}, 32'(fall),   32'(m_fall));
  endtask

  // Present v, let one edge sample it, then compare 1 ns after the edge.
  task automatic step(input logic [N-1:0] v, input string tag);
    raw_in = v;
    @(posedge clk);
    if (rst_n) model_edge(v);
    else       model_reset();
    #1;
    check_outputs(tag);
  endtask

  // Hold v until the chosen pulse appears on channel ch; lat = edges after
  // the first edge that sampled v (-1 on timeout).
  task automatic hold_until(input logic [N-1:0] v, input int ch, input bit want_rise,
                            input string tag, output int lat);
    lat = -1;
    for (int n = 0; n < 30; n++) begin
      step(v, tag);
      if (want_rise ? rise[ch] : fall[ch]) begin
        lat = n;
        break;
      end
    end
  endtask

  // Assert reset between edges, check outputs clear immediately, hold, release.
  task automatic async_reset(input logic [N-1:0] v, input int hold, input string tag);
    raw_in = v;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs({tag, "_imm"});
    @(posedge clk);
    #1;
    repeat (hold) step(v, {tag, "_hold"});
    rst_n = 1'b1;
  endtask

  int lat;
  int rc;

  initial begin
    for (int i = 0; i < N; i++) m_run[i] = 0;

    // Reset held with both inputs high, then release: full debounce on both.
    repeat (3) step(2'b11, "reset");
    rst_n = 1'b1;
    hold_until(2'b11, 0, 1'b1, "rst_release", lat);
    check("rst_release_lat", 32'(lat), 32'(SC + 2));
    check("rst_release_rise", 32'(rise), 32'(2'b11));
    repeat (3) step(2'b11, "rst_idle");

    // Release both, then a clean press on channel 0 only.
    hold_until(2'b00, 0, 1'b0, "rel_both", lat);
    check("rel_both_lat", 32'(lat), 32'(SC + 2));
    repeat (3) step(2'b00, "idle0");
    hold_until(2'b01, 0, 1'b1, "press0", lat);
    check("press0_lat", 32'(lat), 32'(SC + 2));
    check("press0_db", 32'(db_out), 32'(2'b01));
    repeat (3) step(2'b01, "press0_hold");
    hold_until(2'b00, 0, 1'b0, "rel0", lat);
    repeat (3) step(2'b00, "idle1");

    // Bounce rejection: 3 high, 2 low, 3 high, then low; no pulse expected.
    rc = 0;
    foreach (lat_pat_bounce[j]) begin
      step(lat_pat_bounce[j], "bounce");
      rc += int'(rise[0]);
    end
    repeat (12) begin
      step(2'b00, "bounce_tail");
      rc += int'(rise[0]);
    end
    check("bounce_rise_cnt", 32'(rc), 32'd0);
    check("bounce_db", 32'(db_out), 32'd0);

    // Alternate 1,0,1,0 then hold 1: one rise, 6 edges after the final 0->1.
    step(2'b01, "alt"); step(2'b00, "alt"); step(2'b01, "alt"); step(2'b00, "alt");
    hold_until(2'b01, 0, 1'b1, "settle", lat);
    check("settle_lat", 32'(lat), 32'(SC + 2));
    rc = 0;
    repeat (12) begin
      step(2'b01, "settle_hold");
      rc += int'(rise[0]);
    end
    check("settle_single_rise", 32'(rc), 32'd0);

    // Channel 1 presses while channel 0 releases on the same edge.
    hold_until(2'b10, 1, 1'b1, "indep", lat);
    check("indep_lat", 32'(lat), 32'(SC + 2));
    check("indep_fall0", 32'(fall[0]), 32'd1);
    check("indep_db", 32'(db_out), 32'(2'b10));
    step(2'b10, "indep_after");

    // Reset while a level is high: output must clear without waiting for clk.
    async_reset(2'b00, 2, "rst_hi");
    check("rst_hi_db", 32'(db_out), 32'd0);
    repeat (8) step(2'b00, "rst_hi_idle");

    // Reset part-way through WAIT_HI (cnt=2), raw stays high: full debounce again.
    repeat (4) step(2'b01, "wait_hi");
    async_reset(2'b01, 2, "rst_wait");
    hold_until(2'b01, 0, 1'b1, "rst_wait_rel", lat);
    check("rst_wait_lat", 32'(lat), 32'(SC + 2));

    // Randomised phase: mostly-held levels with bursts of flips, rare resets.
    begin
      logic [N-1:0] v;
      v = raw_in;
      for (int c = 0; c < 3000; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(5, 0) == 0) v[i] = ~v[i];
        if ($urandom_range(599, 0) == 0) async_reset(v, int'($urandom_range(3, 0)), "rnd_rst");
        step(v, "rnd");
        check("rnd_excl", 32'(rise & fall), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bounce pattern for channel 0 (applied one entry per edge).
  logic [N-1:0] lat_pat_bounce [9] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
                                       2'b01, 2'b01, 2'b01, 2'b00};

endmodule : tb_sw_debounce
